// File: rtl/engine_loop_sequencer.sv
// Nested N-level loop controller around an ap_start/ap_ready/ap_done engine.
// Two nested counter sets track accepted inputs (ready) and completed iterations (done).
module engine_loop_sequencer #(
    parameter int NUM_LEVELS = 2,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [NUM_LEVELS*CNT_W-1:0] max_i,
    output logic                        low_start_o,
    input  logic                        low_ready_i,
    input  logic                        low_done_i,
    output logic                        idle_o,
    output logic                        ready_o,
    output logic                        done_o,
    output logic [NUM_LEVELS*CNT_W-1:0] iter_idx_o,
    output logic [1:0]                  err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [NUM_LEVELS-1:0][CNT_W-1:0] cnt_t;

    state_e     state_q, state_d;
    cnt_t       max_q, max_d;
    cnt_t       rcnt_q, rcnt_d;
    cnt_t       dcnt_q, dcnt_d;
    logic [1:0] err_q, err_d;
    cnt_t       max_in_s;
    logic       r_last_s, d_last_s, zero_trip_s, ready_s;

    // Odometer increment: each level wraps at lim-1 and carries upward.
    function automatic cnt_t cnt_next(input cnt_t cnt, input cnt_t lim);
        cnt_t nxt;
        logic carry;
        nxt   = cnt;
        carry = 1'b1;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (carry) begin
                if (cnt[k] == lim[k] - CNT_W'(1)) begin
                    nxt[k] = '0;
                end else begin
                    nxt[k] = cnt[k] + CNT_W'(1);
                    carry  = 1'b0;
                end
            end else begin
                nxt[k] = cnt[k];
            end
        end
        return nxt;
    endfunction

    function automatic logic all_last(input cnt_t cnt, input cnt_t lim);
        logic res;
        res = 1'b1;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (cnt[k] != lim[k] - CNT_W'(1)) begin
                res = 1'b0;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic any_zero(input cnt_t lim);
        logic res;
        res = 1'b0;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (lim[k] == CNT_W'(0)) begin
                res = 1'b1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign max_in_s    = max_i;
    assign r_last_s    = all_last(rcnt_q, max_q);
    assign d_last_s    = all_last(dcnt_q, max_q);
    assign zero_trip_s = any_zero(max_in_s);

    // Next-state, counter and error-flag logic.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        rcnt_d  = rcnt_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        ready_s = 1'b0;
        if (clear_i) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        max_d  = max_in_s;
                        rcnt_d = '0;
                        dcnt_d = '0;
                        if (zero_trip_s) begin
                            state_d = ST_DONE;
                            err_d   = 2'b01;
                        end else begin
                            state_d = ST_RUN;
                            err_d   = 2'b00;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                    if (low_ready_i || low_done_i) begin
                        err_d[1] = 1'b1;
                    end else begin
                        err_d[1] = err_d[1];
                    end
                end
                ST_RUN: begin
                    if (low_ready_i) begin
                        rcnt_d  = cnt_next(rcnt_q, max_q);
                        ready_s = r_last_s;
                    end else begin
                        rcnt_d = rcnt_q;
                    end
                    if (low_done_i) begin
                        dcnt_d = cnt_next(dcnt_q, max_q);
                    end else begin
                        dcnt_d = dcnt_q;
                    end
                    // A same-cycle final done skips the drain phase entirely.
                    if (low_ready_i && r_last_s) begin
                        state_d = (low_done_i && d_last_s) ? ST_DONE : ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (low_ready_i) begin
                        err_d[1] = 1'b1;
                    end else begin
                        err_d[1] = err_q[1];
                    end
                    if (low_done_i) begin
                        dcnt_d  = cnt_next(dcnt_q, max_q);
                        state_d = d_last_s ? ST_DONE : ST_DRAIN;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    if (low_ready_i || low_done_i) begin
                        err_d[1] = 1'b1;
                    end else begin
                        err_d[1] = err_q[1];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, trip-count latch, counters and sticky error flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            max_q   <= '0;
            rcnt_q  <= '0;
            dcnt_q  <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            rcnt_q  <= rcnt_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
        end
    end

    assign idle_o      = (state_q == ST_IDLE);
    assign low_start_o = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign ready_o     = ready_s;
    assign iter_idx_o  = dcnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_engine_loop_sequencer.sv
// Scoreboard bench: stimulus pushes expected ready/done/index events, a monitor pops and compares.
module tb_engine_loop_sequencer;

    localparam logic [1:0] K_R = 2'd0;
    localparam logic [1:0] K_D = 2'd1;
    localparam logic [1:0] K_I = 2'd2;

    typedef struct packed {
        logic        unit;
        logic [1:0]  kind;
        logic [31:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic start0 = 1'b0, rdy0 = 1'b0, dn0 = 1'b0;
    logic start1 = 1'b0, rdy1 = 1'b0, dn1 = 1'b0;
    logic [31:0] max0 = 32'd0;
    logic [15:0] max1 = 16'd0;

    logic        ls0, idle0, ready0, done0;
    logic [31:0] idx0;
    logic [1:0]  err0;
    logic        ls1, idle1, ready1, done1;
    logic [15:0] idx1;
    logic [1:0]  err1;

    logic [1:0]  rdy_m, dn_m;
    logic [31:0] idx_m [2];
    logic [1:0]  err_m [2];
    logic [31:0] prev_idx [2];

    always #5 clk = ~clk;

    engine_loop_sequencer #(.NUM_LEVELS(2), .CNT_W(16)) u0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start0), .max_i(max0),
        .low_start_o(ls0), .low_ready_i(rdy0), .low_done_i(dn0), .idle_o(idle0),
        .ready_o(ready0), .done_o(done0), .iter_idx_o(idx0), .err_o(err0)
    );

    engine_loop_sequencer #(.NUM_LEVELS(1), .CNT_W(16)) u1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start1), .max_i(max1),
        .low_start_o(ls1), .low_ready_i(rdy1), .low_done_i(dn1), .idle_o(idle1),
        .ready_o(ready1), .done_o(done1), .iter_idx_o(idx1), .err_o(err1)
    );

    assign rdy_m    = {ready1, ready0};
    assign dn_m     = {done1, done0};
    assign idx_m[0] = idx0;
    assign idx_m[1] = {16'd0, idx1};
    assign err_m[0] = err0;
    assign err_m[1] = err1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input logic u, input logic [1:0] k, input logic [31:0] v);
        ev_t e;
        e.unit = u;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int u, input logic [1:0] k, input logic [31:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got unit %0d kind %0d val %0h expected none at %0t",
                     u, k, v, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event", {u[0], k, v}, {e.unit, e.kind, e.val});
        end
    endtask

    // Monitor: every DUT-presented event is matched against the expected queue.
    initial begin
        prev_idx[0] = 32'd0;
        prev_idx[1] = 32'd0;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rdy_m[u]) observe(u, K_R, 32'd0);
                if (dn_m[u]) observe(u, K_D, {30'd0, err_m[u]});
                if (rst) begin
                    prev_idx[u] = idx_m[u];
                end else if (idx_m[u] != prev_idx[u]) begin
                    observe(u, K_I, idx_m[u]);
                    prev_idx[u] = idx_m[u];
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_u0(input logic [31:0] m);
        max0   = m;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // One ready pulse then one done pulse on u0, each followed by an idle cycle.
    task automatic pair0(input bit last_rdy, input bit last_done, input logic [31:0] idx);
        if (last_rdy) expect_ev(1'b0, K_R, 32'd0);
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        chk("low_start_after_ready", ls0, !last_rdy);
        tick();
        if (last_done) expect_ev(1'b0, K_D, 32'd0);
        expect_ev(1'b0, K_I, idx);
        dn0 = 1'b1;
        tick();
        dn0 = 1'b0;
        tick();
        if (last_done) chk("idle_after_done", idle0, 1'b1);
    endtask

    logic [31:0] t1_idx [1:6];

    initial begin
        t1_idx[1] = 32'h0000_0001;
        t1_idx[2] = 32'h0000_0002;
        t1_idx[3] = 32'h0001_0000;
        t1_idx[4] = 32'h0001_0001;
        t1_idx[5] = 32'h0001_0002;
        t1_idx[6] = 32'h0000_0000;

        #2;
        chk("rst_idle", idle0, 1'b1);
        chk("rst_low_start", ls0, 1'b0);
        chk("rst_ready", ready0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_err", err0, 2'b00);
        chk("rst_idx", idx0, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Two-level job: L0=3, L1=2.
        start_u0({16'd2, 16'd3});
        chk("t1_low_start", ls0, 1'b1);
        chk("t1_idle", idle0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            pair0(i == 6, i == 6, t1_idx[i]);
        end

        // Zero trip count on level 0.
        expect_ev(1'b0, K_D, 32'd1);
        start_u0({16'd4, 16'd0});
        chk("t2_low_start", ls0, 1'b0);
        chk("t2_err", err0, 2'b01);
        tick();
        chk("t2_idle", idle0, 1'b1);
        chk("t2_low_start_idle", ls0, 1'b0);
        tick();

        // Single level, max=1, ready and done together.
        max1   = 16'd1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t3_low_start", ls1, 1'b1);
        expect_ev(1'b1, K_R, 32'd0);
        expect_ev(1'b1, K_D, 32'd0);
        rdy1 = 1'b1;
        dn1  = 1'b1;
        tick();
        rdy1 = 1'b0;
        dn1  = 1'b0;
        chk("t3_no_drain", ls1, 1'b0);
        chk("t3_not_idle", idle1, 1'b0);
        tick();
        chk("t3_idle", idle1, 1'b1);

        // Restart mid-RUN is ignored; exactly four iterations.
        start_u0({16'd2, 16'd2});
        max0   = {16'd5, 16'd5};
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("t4_still_run", ls0, 1'b1);
        pair0(1'b0, 1'b0, 32'h0000_0001);
        pair0(1'b0, 1'b0, 32'h0001_0000);
        pair0(1'b0, 1'b0, 32'h0001_0001);
        pair0(1'b1, 1'b1, 32'h0000_0000);

        // Soft clear after two of four dones.
        start_u0({16'd2, 16'd2});
        pair0(1'b0, 1'b0, 32'h0000_0001);
        pair0(1'b0, 1'b0, 32'h0001_0000);
        expect_ev(1'b0, K_I, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_idle", idle0, 1'b1);
        chk("t5_low_start", ls0, 1'b0);
        tick();
        dn0 = 1'b1;
        tick();
        dn0 = 1'b0;
        chk("t5_spurious_err", err0, 2'b10);
        tick();

        // Async reset in DRAIN, then a fresh full job.
        start_u0({16'd1, 16'd2});
        expect_ev(1'b0, K_R, 32'd0);
        rdy0 = 1'b1;
        tick();
        chk("t6_run", ls0, 1'b1);
        tick();
        rdy0 = 1'b0;
        chk("t6_drain", ls0, 1'b0);
        expect_ev(1'b0, K_I, 32'd1);
        dn0 = 1'b1;
        tick();
        dn0 = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_idle", idle0, 1'b1);
        chk("t6_rst_low_start", ls0, 1'b0);
        chk("t6_rst_done", done0, 1'b0);
        chk("t6_rst_idx", idx0, 32'd0);
        chk("t6_rst_err", err0, 2'b00);
        tick();
        rst = 1'b0;
        tick();
        start_u0({16'd1, 16'd2});
        chk("t6_restart", ls0, 1'b1);
        pair0(1'b0, 1'b0, 32'h0000_0001);
        pair0(1'b1, 1'b1, 32'h0000_0000);

        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
